// File: rtl/mod2n1_pkg.sv
// Shared constants and helpers for the modulo (2^n-1) arithmetic datapath.
// Contents:
//   WIDTH_DEF  default operand width (modulus 2^WIDTH_DEF-1)
//   MOD_ONES   all-ones word (the "negative zero" residue)
//   L1_SPAN    bits combined per first-level prefix group
//   L2_STRIDE  index stride between groups at the second prefix level
//   op_e       operation select encoding
//   wrap_idx   circular index (i-k) mod w
package mod2n1_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam logic [WIDTH_DEF-1:0] MOD_ONES = '1;
  localparam int unsigned L1_SPAN   = 4;
  localparam int unsigned L2_STRIDE = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned wrap_idx(input int unsigned i,
                                           input int unsigned k,
                                           input int unsigned w);
    return (i + w - (k % w)) % w;
  endfunction

endpackage

// File: rtl/mod2n1_prefix_cell.sv
// Four-input generate/propagate group cell for the circular prefix network.
// Ports:
//   g[3:0]  generates, g[3] is the most significant (closest) position
//   p[3:0]  propagates, same ordering as g
//   gg      group generate
//   pp      group propagate
module mod2n1_prefix_cell (
  input  logic [3:0] g,
  input  logic [3:0] p,
  output logic       gg,
  output logic       pp
);

  always_comb begin
    gg = g[3]
       | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    pp = &p;
  end

endmodule

// File: rtl/mod2n1_addsub_pipe.sv
// Two-stage pipelined add/subtract modulo 2^WIDTH-1 with valid/ready on both
// sides. Subtraction adds the one's complement of b; the carry out of the MSB
// is re-injected at bit 0 through a circular (end-around) prefix network.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_a, in_b, in_sub   operands and op select (1 = a-b, 0 = a+b)
//   out_valid/out_ready  output handshake
//   out_data             residue result
module mod2n1_addsub_pipe
  import mod2n1_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter bit          NORM_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             adv1, adv2;
  logic             s1_valid;
  logic [WIDTH-1:0] bb, g0, p0, x0;
  logic [WIDTH-1:0] g1_d, p1_d;
  logic [WIDTH-1:0] g1_q, p1_q, x_q;
  logic [WIDTH-1:0] g2, pr2_unused;
  logic [WIDTH-1:0] sum, res;

  // Handshake: each stage advances when it is empty or its consumer moves.
  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  // Stage 0: operand conditioning and bitwise g/p/x.
  always_comb begin
    bb = (op_e'(in_sub) == OP_SUB) ? ~in_b : in_b;
    g0 = in_a & bb;
    p0 = in_a | bb;
    x0 = in_a ^ bb;
  end

  // First prefix level: group over bits i..i-3, wrapping around the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_l1
    localparam int unsigned I1 = wrap_idx(i, 1, WIDTH);
    localparam int unsigned I2 = wrap_idx(i, 2, WIDTH);
    localparam int unsigned I3 = wrap_idx(i, L1_SPAN - 1, WIDTH);
    mod2n1_prefix_cell u_cell (
      .g  ({g0[i], g0[I1], g0[I2], g0[I3]}),
      .p  ({p0[i], p0[I1], p0[I2], p0[I3]}),
      .gg (g1_d[i]),
      .pp (p1_d[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      g1_q     <= '0;
      p1_q     <= '0;
      x_q      <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      g1_q     <= g1_d;
      p1_q     <= p1_d;
      x_q      <= x0;
    end
  end

  // Second prefix level: four level-1 groups at stride 4 cover the full
  // circle, so G2[i] is the carry out of position i including wrap-around.
  for (genvar i = 0; i < WIDTH; i++) begin : g_l2
    localparam int unsigned J1 = wrap_idx(i, L2_STRIDE, WIDTH);
    localparam int unsigned J2 = wrap_idx(i, 2 * L2_STRIDE, WIDTH);
    localparam int unsigned J3 = wrap_idx(i, 3 * L2_STRIDE, WIDTH);
    localparam int unsigned JC = wrap_idx(i, 1, WIDTH);
    mod2n1_prefix_cell u_cell (
      .g  ({g1_q[i], g1_q[J1], g1_q[J2], g1_q[J3]}),
      .p  ({p1_q[i], p1_q[J1], p1_q[J2], p1_q[J3]}),
      .gg (g2[i]),
      .pp (pr2_unused[i])
    );
    assign sum[i] = x_q[i] ^ g2[JC];
  end

  always_comb begin
    res = sum;
    if (NORM_ZERO && (sum == '1)) begin
      res = '0;
    end
  end

  // out_data only loads with a real beat, so bubbles never overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_mod2n1_addsub_pipe.sv
// Self-checking bench for mod2n1_addsub_pipe: directed vector table,
// backpressure and reset sequences, and a randomized stream against an
// arithmetic reference model. Two instances share stimulus: NORM_ZERO=1 and 0.
module tb_mod2n1_addsub_pipe;
  import mod2n1_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic        in_ready0, out_valid0;
  logic [15:0] out_data0;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  mod2n1_addsub_pipe #(.WIDTH(16), .NORM_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  mod2n1_addsub_pipe #(.WIDTH(16), .NORM_ZERO(1'b0)) dut_nz0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp1;  // NORM_ZERO=1
    logic [15:0] exp0;  // NORM_ZERO=0
  } vec_t;

  localparam int NV = 11;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Residue arithmetic from first principles: reduce, add/subtract, reduce.
  function automatic int unsigned ref_res(input logic sub, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned av, bv;
    av = int'(a) % 65535;
    bv = int'(b) % 65535;
    return sub ? (av + 65535 - bv) % 65535 : (av + bv) % 65535;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned q[$];
    logic [15:0] bp_a [4];
    logic [15:0] bp_b [4];
    logic        bp_s [4];
    logic [15:0] bp_e [4];
    int          accepts, got, sent, cnt;
    logic [15:0] held_data, frozen;
    logic        held, acc;
    int unsigned e;

    tv[0]  = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 16'h0002};
    tv[1]  = '{1'b1, 16'h0003, 16'h0005, 16'hFFFD, 16'hFFFD};
    tv[2]  = '{1'b0, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001};
    tv[3]  = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFE, 16'hFFFE};
    tv[4]  = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 16'hFFFF};
    tv[5]  = '{1'b0, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    tv[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tv[7]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    tv[8]  = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 16'h2345};
    tv[9]  = '{1'b1, 16'h0000, 16'h0001, 16'hFFFE, 16'hFFFE};
    tv[10] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF};

    bp_s[0] = 1'b0; bp_a[0] = 16'h0001; bp_b[0] = 16'h0002; bp_e[0] = 16'h0003;
    bp_s[1] = 1'b1; bp_a[1] = 16'h000A; bp_b[1] = 16'h0004; bp_e[1] = 16'h0006;
    bp_s[2] = 1'b0; bp_a[2] = 16'h0100; bp_b[2] = 16'h0200; bp_e[2] = 16'h0300;
    bp_s[3] = 1'b1; bp_a[3] = 16'h0000; bp_b[3] = 16'h0005; bp_e[3] = 16'hFFFA;

    // Reset state.
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors: result and exact 2-cycle latency.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sub = tv[i].sub; in_a = tv[i].a; in_b = tv[i].b;
      out_ready = 1'b1;
      #1 chk($sformatf("tv%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk($sformatf("tv%0d_lat1_valid", i), out_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("tv%0d_lat2_valid", i), out_valid, 1);
      chk($sformatf("tv%0d_nz1", i), out_data, tv[i].exp1);
      chk($sformatf("tv%0d_nz0", i), out_data0, tv[i].exp0);
    end

    // Backpressure: fill both stages, hold, then drain in order.
    @(negedge clk);
    out_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (accepts < 4);
      in_sub = bp_s[accepts % 4]; in_a = bp_a[accepts % 4]; in_b = bp_b[accepts % 4];
      #1;
      if (in_valid && in_ready) accepts++;
    end
    chk("bp_accepts", accepts, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_first_data", out_data, bp_e[0]);
    frozen = out_data;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_frozen_valid", out_valid, 1);
      chk("bp_frozen_data", out_data, frozen);
    end
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      in_valid = (accepts < 4);
      in_sub = bp_s[accepts % 4]; in_a = bp_a[accepts % 4]; in_b = bp_b[accepts % 4];
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (got < 4) chk($sformatf("bp_out%0d", got), out_data, bp_e[got]);
        got++;
      end
      if (in_valid && in_ready) accepts++;
    end
    chk("bp_got_all", got, 4);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("bp_no_duplicate", cnt, 0);

    // Randomized stream against the reference model.
    sent = 0; got = 0; held = 1'b0; acc = 1'b0; held_data = '0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() > 0); cyc++) begin
      @(negedge clk);
      if (held) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, held_data);
      end
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_sub = $urandom_range(0, 1);
        in_a = 16'($urandom);
        case ($urandom_range(0, 7))
          0: in_b = in_a;
          1: in_a = 16'hFFFF;
          2: in_b = 16'hFFFF;
          default: in_b = 16'($urandom);
        endcase
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_ready) chk("full_rate_ready", in_ready, 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rand_nz1", out_data, e);
          chk("rand_nz0_mod", 32'(out_data0) % 65535, e);
        end
        got++;
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) begin
        q.push_back(ref_res(in_sub, in_a, in_b));
        sent++;
        acc = 1'b1;
      end
    end
    chk("rand_sent", sent, 1000);
    chk("rand_got", got, 1000);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sub = 1'b1; in_a = 16'h0005; in_b = 16'h0003;
    @(negedge clk);
    in_sub = 1'b0; in_a = 16'h0001; in_b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("inflight_out_valid", out_valid, 1);
    chk("inflight_in_ready", in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("rst_release_in_ready", in_ready, 1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("no_stale_after_rst", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
